// File: rtl/cfg_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cfg_txn_ctrl
// Brief    : Turns config-space read/write command pulses into transport
//            requests, with response wait, timeout and bounded retry.
// Revision : 1.0 - initial release
// ============================================================================
module cfg_txn_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_read_pul,
    input  logic              s_write_pul,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    input  logic              trans_error_pul,
    input  logic              t_valid_pul,
    input  logic [DATA_W-1:0] t_rdata,
    output logic              t_req,
    output logic              t_write,
    output logic [ADDR_W-1:0] t_addr,
    output logic [DATA_W-1:0] t_wdata,
    output logic [DATA_W-1:0] s_rdata,
    output logic              s_done,
    output logic              s_err,
    output logic              busy,
    output logic [3:0]        retry_cnt
);

    localparam logic [3:0]  c_max_retry = MAX_RETRY[3:0];
    localparam logic [15:0] c_timeout   = TIMEOUT[15:0];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    // r_timer holds the number of the current WAIT cycle (1..TIMEOUT)
    logic [15:0]       r_timer;
    logic [15:0]       w_timer_nxt;

    logic              w_t_req;
    logic              w_t_write;
    logic [ADDR_W-1:0] w_t_addr;
    logic [DATA_W-1:0] w_t_wdata;
    logic [DATA_W-1:0] w_s_rdata;
    logic              w_s_done;
    logic              w_s_err;
    logic              w_busy;
    logic [3:0]        w_retry_cnt;

    logic              w_cmd_one;
    logic              w_cmd_both;
    logic              w_err_evt;

    assign w_cmd_one  = s_read_pul ^ s_write_pul;
    assign w_cmd_both = s_read_pul & s_write_pul;
    // Error beats a coincident valid; a valid in the last WAIT cycle still wins over timeout
    assign w_err_evt  = trans_error_pul | (~t_valid_pul & (r_timer == c_timeout));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            t_req     <= 1'b0;
            t_write   <= 1'b0;
            t_addr    <= '0;
            t_wdata   <= '0;
            s_rdata   <= '0;
            s_done    <= 1'b0;
            s_err     <= 1'b0;
            busy      <= 1'b0;
            retry_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            t_req     <= w_t_req;
            t_write   <= w_t_write;
            t_addr    <= w_t_addr;
            t_wdata   <= w_t_wdata;
            s_rdata   <= w_s_rdata;
            s_done    <= w_s_done;
            s_err     <= w_s_err;
            busy      <= w_busy;
            retry_cnt <= w_retry_cnt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_t_write   = t_write;
        w_t_addr    = t_addr;
        w_t_wdata   = t_wdata;
        w_s_rdata   = s_rdata;
        w_s_done    = 1'b0;
        w_s_err     = 1'b0;
        w_retry_cnt = retry_cnt;

        case (r_state)
            ST_IDLE: begin
                if (w_cmd_one) begin
                    w_t_write   = s_write_pul;
                    w_t_addr    = s_addr;
                    if (s_write_pul) begin
                        w_t_wdata = s_wdata;
                    end
                    w_retry_cnt = 4'd0;
                    w_state_nxt = ST_ISSUE;
                end else if (w_cmd_both) begin
                    w_s_err = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_timer_nxt = 16'd1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_err_evt) begin
                    if (retry_cnt < c_max_retry) begin
                        w_retry_cnt = retry_cnt + 4'd1;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_s_err     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (t_valid_pul) begin
                    if (!t_write) begin
                        w_s_rdata = t_rdata;
                    end
                    w_s_done    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 16'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_t_req = (w_state_nxt == ST_ISSUE);
        w_busy  = (w_state_nxt != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_cfg_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cfg_txn_ctrl
// Brief    : Randomized bench for cfg_txn_ctrl against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfg_txn_ctrl;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int MAX_RETRY = 3;
    localparam int TIMEOUT   = 64;
    localparam int N_CYCLES  = 6000;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_read_pul;
    logic              s_write_pul;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata;
    logic              trans_error_pul;
    logic              t_valid_pul;
    logic [DATA_W-1:0] t_rdata;
    logic              t_req;
    logic              t_write;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata;
    logic [DATA_W-1:0] s_rdata;
    logic              s_done;
    logic              s_err;
    logic              busy;
    logic [3:0]        retry_cnt;

    always #5 clk = ~clk;

    cfg_txn_ctrl #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_RETRY (MAX_RETRY),
        .TIMEOUT   (TIMEOUT)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .s_read_pul      (s_read_pul),
        .s_write_pul     (s_write_pul),
        .s_addr          (s_addr),
        .s_wdata         (s_wdata),
        .trans_error_pul (trans_error_pul),
        .t_valid_pul     (t_valid_pul),
        .t_rdata         (t_rdata),
        .t_req           (t_req),
        .t_write         (t_write),
        .t_addr          (t_addr),
        .t_wdata         (t_wdata),
        .s_rdata         (s_rdata),
        .s_done          (s_done),
        .s_err           (s_err),
        .busy            (busy),
        .retry_cnt       (retry_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Expected outputs for the upcoming cycle plus transaction bookkeeping
    bit              e_req, e_write, e_done, e_err, e_busy;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata, e_rdata;
    int              e_retry;
    int              m_wait_no;
    int              n_done, n_err, n_tmo_ok;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advances the model by one clock using the inputs about to be sampled
    task automatic model_step();
        bit was_busy, was_issue;
        was_busy  = e_busy;
        was_issue = e_req;
        e_req  = 1'b0;
        e_done = 1'b0;
        e_err  = 1'b0;
        if (reset) begin
            e_write = 1'b0; e_addr = '0; e_wdata = '0; e_rdata = '0;
            e_busy = 1'b0; e_retry = 0; m_wait_no = 0;
        end else if (!was_busy) begin
            if (s_read_pul != s_write_pul) begin
                e_write = s_write_pul;
                e_addr  = s_addr;
                if (s_write_pul) e_wdata = s_wdata;
                e_retry = 0;
                e_req   = 1'b1;
                e_busy  = 1'b1;
            end else if (s_read_pul) begin
                e_err = 1'b1;
            end
        end else if (was_issue) begin
            m_wait_no = 1;
        end else begin
            if (trans_error_pul || (!t_valid_pul && m_wait_no == TIMEOUT)) begin
                if (e_retry < MAX_RETRY) begin
                    e_retry++;
                    e_req = 1'b1;
                end else begin
                    e_err  = 1'b1;
                    e_busy = 1'b0;
                end
            end else if (t_valid_pul) begin
                if (!e_write) e_rdata = t_rdata;
                if (m_wait_no == TIMEOUT) n_tmo_ok++;
                e_done = 1'b1;
                e_busy = 1'b0;
            end else begin
                m_wait_no++;
            end
        end
    endtask

    initial begin
        int phase, r;
        bit in_wait;
        reset = 1'b1; s_read_pul = 1'b0; s_write_pul = 1'b0;
        s_addr = '0; s_wdata = '0; trans_error_pul = 1'b0;
        t_valid_pul = 1'b0; t_rdata = '0;
        e_req = 0; e_write = 0; e_done = 0; e_err = 0; e_busy = 0;
        e_addr = '0; e_wdata = '0; e_rdata = '0; e_retry = 0; m_wait_no = 0;
        n_done = 0; n_err = 0; n_tmo_ok = 0;
        model_step();

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            chk("t_req",     64'(t_req),     64'(e_req));
            chk("t_write",   64'(t_write),   64'(e_write));
            chk("t_addr",    64'(t_addr),    64'(e_addr));
            chk("t_wdata",   64'(t_wdata),   64'(e_wdata));
            chk("s_rdata",   64'(s_rdata),   64'(e_rdata));
            chk("s_done",    64'(s_done),    64'(e_done));
            chk("s_err",     64'(s_err),     64'(e_err));
            chk("busy",      64'(busy),      64'(e_busy));
            chk("retry_cnt", 64'(retry_cnt), 64'(e_retry));
            if (e_done) n_done++;
            if (e_err)  n_err++;

            phase   = (cyc / 600) % 5;
            in_wait = e_busy && !e_req;
            reset   = (cyc < 3) || ($urandom_range(0, 999) == 0);
            r = $urandom_range(0, 99);
            s_read_pul  = (r < 8) || (phase == 3 && r >= 96);
            s_write_pul = (r >= 8 && r < 16) || (phase == 3 && r >= 96);
            s_addr  = ADDR_W'($urandom);
            s_wdata = $urandom;
            t_rdata = $urandom;
            case (phase)
                0: begin
                    t_valid_pul     = ($urandom_range(0, 5) == 0);
                    trans_error_pul = ($urandom_range(0, 19) == 0);
                end
                1: begin
                    t_valid_pul     = 1'b0;
                    trans_error_pul = 1'b0;
                end
                2: begin
                    t_valid_pul     = ($urandom_range(0, 4) == 0);
                    trans_error_pul = ($urandom_range(0, 2) == 0);
                end
                3: begin
                    t_valid_pul     = ($urandom_range(0, 7) == 0);
                    trans_error_pul = ($urandom_range(0, 7) == 0);
                end
                default: begin
                    // Land responses exactly on the last allowed WAIT cycle
                    t_valid_pul     = in_wait && (m_wait_no == TIMEOUT) && ($urandom_range(0, 1) == 0);
                    trans_error_pul = 1'b0;
                end
            endcase
            model_step();
        end

        chk("saw_done",       64'(n_done > 0),   64'd1);
        chk("saw_err",        64'(n_err > 0),    64'd1);
        chk("saw_last_cycle", 64'(n_tmo_ok > 0), 64'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
